// File: rtl/seq_divider_nbit_if.sv
// rtl/seq_divider_nbit_if.sv - start/done handshake and operand/result bundle for the sequential divider
interface seq_divider_nbit_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  // Control unit side: issues requests, observes results
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_nbit.sv
// rtl/seq_divider_nbit.sv - multi-cycle unsigned restoring divider, one quotient bit per cycle
module seq_divider_nbit #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_divider_nbit_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  // Working registers: Q doubles as dividend shifter and quotient collector,
  // R is one bit wider than the operands so the trial subtraction never overflows.
  logic [N-1:0]  q_reg;
  logic [N-1:0]  d_reg;
  logic [N:0]    r_reg;
  logic [CW-1:0] count;

  // Registered outputs
  logic          busy_reg;
  logic          done_reg;
  logic          dbz_reg;
  logic [N-1:0]  quot_reg;
  logic [N-1:0]  rem_reg;

  logic          accept;
  logic          last_iter;
  logic          zero_divisor;

  // Datapath for one iteration
  logic [N:0]    a_op;
  logic [N:0]    b_op;
  logic [N:0]    trial;
  logic [N+1:0]  carry;
  logic          trial_ok;
  logic [N:0]    r_iter;
  logic [N-1:0]  q_iter;

  // After a restoring step R is always below D, so its top bit is zero
  // and never shifted into the next partial remainder.
  logic          unused_r_msb;
  assign unused_r_msb = r_reg[N];

  assign zero_divisor = (bus.divisor == '0);

  // Shift {R,Q} left by one; the new partial remainder picks up Q's MSB
  assign a_op = {r_reg[N-1:0], q_reg[N-1]};
  // Subtract by adding the inverted zero-extended divisor with carry-in of one
  assign b_op     = ~{1'b0, d_reg};
  assign carry[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i <= N; i++) begin : g_fa
      assign trial[i]   = a_op[i] ^ b_op[i] ^ carry[i];
      assign carry[i+1] = (a_op[i] & b_op[i]) | (carry[i] & (a_op[i] ^ b_op[i]));
    end
  endgenerate

  // Carry-out set means the difference is non-negative: keep it, quotient bit 1
  assign trial_ok = carry[N+1];
  assign r_iter   = trial_ok ? trial : a_op;
  assign q_iter   = {q_reg[N-2:0], trial_ok};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = zero_divisor ? DONE : RUN;
        end
      end
      RUN: begin
        last_iter = (count == CW'(N - 1));
        if (last_iter) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand capture and shift-subtract iterations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
      d_reg <= '0;
      r_reg <= '0;
      count <= '0;
    end else if (accept) begin
      q_reg <= bus.dividend;
      d_reg <= bus.divisor;
      r_reg <= '0;
      count <= '0;
    end else if (state == RUN) begin
      q_reg <= q_iter;
      r_reg <= r_iter;
      count <= count + CW'(1);
    end
  end

  // Result registers: loaded on the edge that enters DONE, held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_reg <= '0;
      rem_reg  <= '0;
      dbz_reg  <= 1'b0;
    end else if (accept) begin
      dbz_reg <= zero_divisor;
      if (zero_divisor) begin
        quot_reg <= '1;
        rem_reg  <= bus.dividend;
      end
    end else if (last_iter) begin
      quot_reg <= q_iter;
      rem_reg  <= r_iter[N-1:0];
    end
  end

  // Status flags registered from the upcoming state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      busy_reg <= (next_state == RUN);
      done_reg <= (next_state == DONE);
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule
